digit_scan_sequencer: RTL and testbench
=======================================

DIGIT_SCAN_SEQUENCER -- requirements
Module: digit_scan_sequencer

Interface
REQ-001 Parameter DWELL, default 1000: clock cycles each digit select is held valid; legal range 1..65535.
REQ-002 Parameter BLANK, default 16: clock cycles of blanking between digits; legal range 1..255; used only when SCAN_BLANK_EN is defined.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  scan enable; 1 = run, 0 = stop and idle.
REQ-006 mask  input  8  digit-active mask; bit i = 1 means digit i is included in the scan.
REQ-007 sel  output  3  binary digit index; drives the downstream 3-to-8 decoder input.
REQ-008 sel_valid  output  1  1 = sel is to be driven onto the display; 0 = idle or blanking.
REQ-009 frame_start  output  1  one-cycle pulse on the first cycle of the lowest active digit of each frame.

Function
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-011 The FSM SHALL have states IDLE, DWELL and BLANK; BLANK exists only with SCAN_BLANK_EN defined.
REQ-012 In IDLE: sel=0, sel_valid=0, frame_start=0.
REQ-013 IDLE->DWELL: on the edge sampling en=1 and mask!=0; sel=lowest set bit of mask, sel_valid=1, frame_start=1 (one cycle).
REQ-014 In DWELL, sel_valid SHALL be 1 for exactly DWELL consecutive cycles, with sel constant.
REQ-015 DWELL->BLANK after the last dwell cycle: sel_valid=0 for exactly BLANK cycles, sel held.
REQ-016 Advance (BLANK->DWELL): next sel = next set bit of mask strictly above current sel; if none exists, wrap to the lowest set bit and pulse frame_start.
REQ-017 mask SHALL be sampled only at advance; mask changes mid-DWELL or mid-BLANK SHALL have no effect until the next advance.
REQ-018 Single set bit in mask: the same digit repeats, and frame_start pulses on every advance.
REQ-019 mask==0 at advance: go to IDLE (outputs per REQ-012).
REQ-020 en sampled 0 in any state: next cycle go to IDLE; a later restart begins at the lowest set bit with frame_start.
REQ-021 Dwell/blank counter width: 16 bits; counter resets on every state entry; no wrap beyond the parameter value.

Reset
REQ-022 rst=1 at a clock edge: state=IDLE, counter=0, sel=0, sel_valid=0, frame_start=0 on the following cycle, regardless of en, mask or current state.
REQ-023 rst SHALL take priority over en and all FSM transitions.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined: BLANK state present; per-digit period = DWELL+BLANK cycles.
REQ-025 SCAN_BLANK_EN undefined: no BLANK state and BLANK ignored; DWELL advances directly to the next DWELL; sel_valid stays 1 across advances; per-digit period = DWELL cycles.

Verification (DWELL=4, BLANK=2, SCAN_BLANK_EN defined unless stated)
REQ-026 mask=8'hFF, en=1 -> sel 0..7, each with sel_valid=1 for 4 cycles then 0 for 2; frame_start every 48 cycles, coincident with sel=0.
REQ-027 mask=8'b1010_0100 -> sel sequence 2,5,7,2,...; frame_start only on sel=2; frame period 18 cycles.
REQ-028 mask=8'hFF, mask changed to 8'h01 during sel=3 dwell -> sel=3 completes 4+2 cycles, then sel=0 with frame_start=1, then sel=0 repeats with frame_start on every advance.
REQ-029 en=0 during the 2nd dwell cycle of sel=5 -> next cycle sel=0, sel_valid=0; en=1 again -> sel=0 (lowest set bit), frame_start=1.
REQ-030 rst=1 during BLANK after sel=6 -> next cycle all outputs 0 and state IDLE, with en held at 1; rst=0 -> restart at sel=0 with frame_start=1.
REQ-031 SCAN_BLANK_EN undefined, mask=8'hFF -> sel_valid constantly 1, sel advances every 4 cycles, frame_start every 32 cycles.

Source files
------------

// File: rtl/digit_scan_sequencer.sv
// Multiplexed display digit scanner: walks the set bits of mask, holding each
// digit select for DWELL cycles. Optional inter-digit blanking via SCAN_BLANK_EN.
module digit_scan_sequencer #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       frame_start
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL} state_t;
  // BLANK has no role without blanking; folding it in at zero weight keeps it referenced
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1 + BLANK * 0);
`endif

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  lowIdx;
  logic [2:0]  nextIdx;
  logic        hasNext;
  logic [2:0]  advSel;
  logic        advFrame;

  // Scanning downward leaves the lowest qualifying bit as the final assignment
  always_comb begin
    lowIdx  = 3'd0;
    nextIdx = 3'd0;
    hasNext = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        lowIdx = 3'(i);
        if (3'(i) > sel) begin
          nextIdx = 3'(i);
          hasNext = 1'b1;
        end
      end
    end
    advSel   = hasNext ? nextIdx : lowIdx;
    advFrame = !hasNext;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      sel         <= 3'd0;
      sel_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mask != 8'd0) begin
            state       <= S_DWELL;
            cnt         <= 16'd0;
            sel         <= lowIdx;
            sel_valid   <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        S_DWELL: begin
          if (cnt == DWELL_LAST) begin
`ifdef SCAN_BLANK_EN
            state     <= S_BLANK;
            cnt       <= 16'd0;
            sel_valid <= 1'b0;
`else
            cnt <= 16'd0;
            if (mask == 8'd0) begin
              state     <= S_IDLE;
              sel       <= 3'd0;
              sel_valid <= 1'b0;
            end else begin
              sel         <= advSel;
              frame_start <= advFrame;
            end
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef SCAN_BLANK_EN
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt <= 16'd0;
            if (mask == 8'd0) begin
              state <= S_IDLE;
              sel   <= 3'd0;
            end else begin
              state       <= S_DWELL;
              sel         <= advSel;
              sel_valid   <= 1'b1;
              frame_start <= advFrame;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          cnt       <= 16'd0;
          sel       <= 3'd0;
          sel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Directed bench for digit_scan_sequencer with DWELL=4, BLANK=2; expectations
// follow whichever SCAN_BLANK_EN setting the build uses.
module tb_digit_scan_sequencer;

  localparam int DW = 4;
  localparam int BL = 2;
`ifdef SCAN_BLANK_EN
  localparam int PER  = DW + BL;
  localparam int RSTK = 6 * PER + 4;
`else
  localparam int PER  = DW;
  localparam int RSTK = 6 * PER + 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       sel_valid;
  logic       frame_start;

  int total = 0;
  int bad   = 0;

  logic [2:0] seqTab [8];
  int         seqLen;

  digit_scan_sequencer #(.DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .mask(mask),
    .sel(sel), .sel_valid(sel_valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] m);
    rst  = r;
    en   = e;
    mask = m;
  endtask

  // Outputs are sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got sel/valid/fs=%b want %b", tag, got, want);
    end
  endtask

  function automatic logic [4:0] obs();
    return {sel, sel_valid, frame_start};
  endfunction

  // Expected {sel, sel_valid, frame_start} k cycles after a scan starts, for seqTab
  function automatic logic [4:0] expScan(input int k);
    int slot = (k / PER) % seqLen;
    int ph   = k % PER;
    return {seqTab[slot], ph < DW, (ph == 0) && (slot == 0)};
  endfunction

  initial begin
    applyStimulus(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_hold", obs(), 5'b000_0_0);
    end

    // Full mask scan over two frames
    applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) seqTab[i] = 3'(i);
    seqLen = 8;
    tick();
    for (int k = 0; k <= 16 * PER; k++) begin
      checkOutput("scan_ff", obs(), expScan(k));
      tick();
    end

    applyStimulus(1'b0, 1'b0, 8'hFF);
    tick();
    checkOutput("en_off_idle", obs(), 5'b000_0_0);

    // Sparse mask 2,5,7
    applyStimulus(1'b0, 1'b1, 8'b1010_0100);
    seqTab[0] = 3'd2; seqTab[1] = 3'd5; seqTab[2] = 3'd7;
    seqLen = 3;
    tick();
    for (int k = 0; k <= 6 * PER; k++) begin
      checkOutput("scan_a4", obs(), expScan(k));
      tick();
    end

    // Mask shrinks to a single digit while sel=3 is dwelling
    applyStimulus(1'b0, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) seqTab[i] = 3'(i);
    seqLen = 8;
    tick();
    for (int k = 0; k < 7 * PER; k++) begin
      if (k < 4 * PER)
        checkOutput("mask_change_pre", obs(), expScan(k));
      else
        checkOutput("mask_change_post", obs(), {3'd0, (k % PER) < DW, (k % PER) == 0});
      if (k == 3 * PER + 1) mask = 8'h01;
      tick();
    end

    // en dropped in the second dwell cycle of sel=5
    applyStimulus(1'b0, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hFF);
    tick();
    for (int k = 0; k <= 5 * PER + 1; k++) begin
      checkOutput("pre_en_drop", obs(), expScan(k));
      if (k == 5 * PER + 1) en = 1'b0;
      tick();
    end
    checkOutput("en_drop_idle", obs(), 5'b000_0_0);
    en = 1'b1;
    tick();
    checkOutput("en_restart", obs(), 5'b000_1_1);
    tick();
    checkOutput("en_restart_2", obs(), 5'b000_1_0);

    // Reset while blanking after sel=6, en held high throughout
    applyStimulus(1'b0, 1'b0, 8'hFF);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hFF);
    tick();
    for (int k = 0; k <= RSTK; k++) begin
      checkOutput("pre_reset", obs(), expScan(k));
      if (k == RSTK) rst = 1'b1;
      tick();
    end
    checkOutput("mid_reset", obs(), 5'b000_0_0);
    tick();
    checkOutput("mid_reset_2", obs(), 5'b000_0_0);
    rst = 1'b0;
    tick();
    checkOutput("reset_restart", obs(), 5'b000_1_1);

    // Single digit repeats with frame_start each advance, then empty mask idles
    applyStimulus(1'b0, 1'b0, 8'h10);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h10);
    seqTab[0] = 3'd4;
    seqLen = 1;
    tick();
    for (int k = 0; k < 3 * PER; k++) begin
      checkOutput("single_digit", obs(), expScan(k));
      if (k == 2 * PER + 1) mask = 8'h00;
      tick();
    end
    checkOutput("empty_mask_idle", obs(), 5'b000_0_0);
    tick();
    checkOutput("empty_mask_stay", obs(), 5'b000_0_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
